// File: rtl/edge_pkg.sv
// Shared types and frame defaults for the edge filter frame path.
// Used by the frame sequencer and its write mapper.
package edge_pkg;

   localparam int IMG_W_DEF  = 638;
   localparam int IMG_H_DEF  = 478;
   localparam int ADDR_W_DEF = 19;
   localparam int FRAME_PIX  = IMG_W_DEF * IMG_H_DEF;
   localparam int BORDER     = 2;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      FLUSH,
      DRAIN,
      DONE
   } seq_state_t;

endpackage

// File: rtl/edge_wr_mapper.sv
// Output side of the frame sequencer: skips the filter warm-up
// strobes, maps window centres to row-major writes, zeroes the border.
module edge_wr_mapper
   import edge_pkg::*;
#(
   parameter int IMG_W      = IMG_W_DEF,
   parameter int IMG_H      = IMG_H_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int CENTER_OFS = 2 * IMG_W + 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [3:0]        pixel,
   input  logic              strobe,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [3:0]        wr_data,
   output logic              last_write
);

   localparam int PIX = IMG_W * IMG_H;
   localparam int RW  = $clog2(IMG_H);
   localparam int CW  = $clog2(IMG_W);

   localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(CENTER_OFS - 1);
   localparam logic [ADDR_W-1:0] M_LAST = ADDR_W'(PIX - 1);
   localparam logic [CW-1:0]     C_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0]     R_LO   = RW'(BORDER);
   localparam logic [RW-1:0]     R_HI   = RW'(IMG_H - 1 - BORDER);
   localparam logic [CW-1:0]     C_LO   = CW'(BORDER);
   localparam logic [CW-1:0]     C_HI   = CW'(IMG_W - 1 - BORDER);

   logic [ADDR_W-1:0] k;
   logic              primed;
   logic [ADDR_W-1:0] m;
   logic [RW-1:0]     r;
   logic [CW-1:0]     c;
   logic              inner;

   // window centre lies inside the 2-pixel border
   always_comb begin
      inner = (r >= R_LO) && (r <= R_HI) &&
              (c >= C_LO) && (c <= C_HI);
   end

   // discard warm-up strobes, then one registered write per strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k          <= '0;
         primed     <= 1'b0;
         m          <= '0;
         r          <= '0;
         c          <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         last_write <= 1'b0;
      end else if (clr) begin
         k          <= '0;
         primed     <= 1'b0;
         m          <= '0;
         r          <= '0;
         c          <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         last_write <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         if (en && strobe && !last_write) begin
            if (!primed) begin
               if (k == K_LAST)
                  primed <= 1'b1;
               else
                  k <= k + 1'b1;
            end else begin
               wr_en   <= 1'b1;
               wr_addr <= m;
               wr_data <= inner ? pixel : 4'd0;
               if (m == M_LAST) begin
                  last_write <= 1'b1;
               end else begin
                  m <= m + 1'b1;
                  if (c == C_LAST) begin
                     c <= '0;
                     r <= r + 1'b1;
                  end else begin
                     c <= c + 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/edge_frame_sequencer.sv
// Frame controller for the 5x5 edge filter: clears the filter, streams a
// frame in gap-free, flushes with zeros and collects aligned results.
module edge_frame_sequencer
   import edge_pkg::*;
#(
   parameter int IMG_W      = IMG_W_DEF,
   parameter int IMG_H      = IMG_H_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int CENTER_OFS = 2 * IMG_W + 2,
   parameter int FLUSH_PAD  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              src_rd_en,
   output logic [ADDR_W-1:0] src_rd_addr,
   input  logic [3:0]        src_rd_data,
   output logic              filt_rst,
   output logic [3:0]        filt_pixel_in,
   output logic              filt_in_ready,
   input  logic [3:0]        filt_pixel_out,
   input  logic              filt_out_ready,
   output logic              dst_wr_en,
   output logic [ADDR_W-1:0] dst_wr_addr,
   output logic [3:0]        dst_wr_data
);

   localparam int PIX = IMG_W * IMG_H;

   localparam logic [ADDR_W-1:0] RD_LAST = ADDR_W'(PIX - 1);
   localparam logic [ADDR_W-1:0] FL_LAST = ADDR_W'(CENTER_OFS + FLUSH_PAD - 1);

   seq_state_t        state;
   seq_state_t        nxt;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] fcnt;
   logic              rd_q;
   logic              flush_q;
   logic              last_write;
   logic              map_clr;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= nxt;
   end

   // next state and state-decoded strobes
   always_comb begin
      nxt       = state;
      busy      = 1'b0;
      done      = 1'b0;
      src_rd_en = 1'b0;
      filt_rst  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start)
               nxt = CLEAR;
         end
         CLEAR: begin
            busy     = 1'b1;
            filt_rst = 1'b1;
            nxt      = FEED;
         end
         FEED: begin
            busy      = 1'b1;
            src_rd_en = 1'b1;
            if (rd_addr == RD_LAST)
               nxt = FLUSH;
         end
         FLUSH: begin
            busy = 1'b1;
            if (fcnt == FL_LAST)
               nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (last_write)
               nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
      if (abort)
         nxt = IDLE;
   end

   // read address, flush length and the one-cycle source alignment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr <= '0;
         fcnt    <= '0;
         rd_q    <= 1'b0;
         flush_q <= 1'b0;
      end else if (abort) begin
         rd_addr <= '0;
         fcnt    <= '0;
         rd_q    <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         rd_q    <= (state == FEED);
         flush_q <= (state == FLUSH);
         if (state == CLEAR)
            rd_addr <= '0;
         else if (state == FEED && rd_addr != RD_LAST)
            rd_addr <= rd_addr + 1'b1;
         fcnt <= (state == FLUSH) ? fcnt + 1'b1 : '0;
      end
   end

   assign src_rd_addr   = rd_addr;
   assign filt_in_ready = rd_q | flush_q;
   assign filt_pixel_in = rd_q ? src_rd_data : 4'd0;
   assign map_clr       = abort | (state == CLEAR);

   edge_wr_mapper #(
      .IMG_W      (IMG_W),
      .IMG_H      (IMG_H),
      .ADDR_W     (ADDR_W),
      .CENTER_OFS (CENTER_OFS)
   ) u_map (
      .clk        (clk),
      .rst        (rst),
      .clr        (map_clr),
      .en         (busy),
      .pixel      (filt_pixel_out),
      .strobe     (filt_out_ready),
      .wr_en      (dst_wr_en),
      .wr_addr    (dst_wr_addr),
      .wr_data    (dst_wr_data),
      .last_write (last_write)
   );

endmodule

// File: tb/tb_edge_frame_sequencer.sv
// Bench for edge_frame_sequencer on an 8x6 frame with a stand-in filter
// and a frame-level reference model.
module tb_edge_frame_sequencer;

   localparam int W   = 8;
   localparam int H   = 6;
   localparam int AW  = 6;
   localparam int CO  = 2 * W + 2;
   localparam int PAD = 2;
   localparam int PIX = W * H;
   localparam int LAT = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          busy;
   logic          done;
   logic          src_rd_en;
   logic [AW-1:0] src_rd_addr;
   logic [3:0]    src_rd_data = 4'd0;
   logic          filt_rst;
   logic [3:0]    filt_pixel_in;
   logic          filt_in_ready;
   logic [3:0]    filt_pixel_out;
   logic          filt_out_ready;
   logic          dst_wr_en;
   logic [AW-1:0] dst_wr_addr;
   logic [3:0]    dst_wr_data;

   edge_frame_sequencer #(
      .IMG_W      (W),
      .IMG_H      (H),
      .ADDR_W     (AW),
      .CENTER_OFS (CO),
      .FLUSH_PAD  (PAD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
      .src_rd_en      (src_rd_en),
      .src_rd_addr    (src_rd_addr),
      .src_rd_data    (src_rd_data),
      .filt_rst       (filt_rst),
      .filt_pixel_in  (filt_pixel_in),
      .filt_in_ready  (filt_in_ready),
      .filt_pixel_out (filt_pixel_out),
      .filt_out_ready (filt_out_ready),
      .dst_wr_en      (dst_wr_en),
      .dst_wr_addr    (dst_wr_addr),
      .dst_wr_data    (dst_wr_data)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] absd(input logic [3:0] a,
                                       input logic [3:0] b);
      return (a > b) ? a - b : b - a;
   endfunction

   // source frame memory, one cycle read latency
   logic [3:0] src [PIX];
   always @(posedge clk)
      if (src_rd_en)
         src_rd_data <= src[src_rd_addr];

   // stand-in filter: |pixel - previous pixel| after LAT strobe cycles
   logic       pv [LAT];
   logic [3:0] pd [LAT];
   logic [3:0] prev;
   always @(posedge clk or posedge rst) begin
      if (rst || filt_rst) begin
         for (int i = 0; i < LAT; i++) begin
            pv[i] <= 1'b0;
            pd[i] <= 4'd0;
         end
         prev <= 4'd0;
      end else begin
         for (int i = LAT - 1; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
         end
         pv[0] <= filt_in_ready;
         pd[0] <= filt_in_ready ? absd(filt_pixel_in, prev) : 4'd0;
         if (filt_in_ready)
            prev <= filt_pixel_in;
      end
   end
   assign filt_out_ready = pv[LAT-1];
   assign filt_pixel_out = pd[LAT-1];

   // observed streams
   logic [3:0] in_q [$];
   int         wa_q [$];
   logic [3:0] wd_q [$];
   int         in_first, in_last, done_n, frst_n, cyc;

   always @(negedge clk) begin
      cyc++;
      if (filt_in_ready) begin
         if (in_q.size() == 0)
            in_first = cyc;
         in_last = cyc;
         in_q.push_back(filt_pixel_in);
      end
      if (dst_wr_en) begin
         wa_q.push_back(int'(dst_wr_addr));
         wd_q.push_back(dst_wr_data);
      end
      if (done)
         done_n++;
      if (filt_rst)
         frst_n++;
   end

   task automatic clear_mon();
      in_q.delete();
      wa_q.delete();
      wd_q.delete();
      done_n = 0;
      frst_n = 0;
   endtask

   // reference: pixel stream seen by the filter, zero beyond the frame
   function automatic logic [3:0] s_at(input int k);
      return (k >= 0 && k < PIX) ? src[k] : 4'd0;
   endfunction

   // reference: destination value for row-major address m
   function automatic logic [3:0] exp_wr(input int m);
      int r, c, k;
      r = m / W;
      c = m % W;
      k = m + CO;
      if (r >= 2 && r <= H - 3 && c >= 2 && c <= W - 3)
         return absd(s_at(k), s_at(k - 1));
      return 4'd0;
   endfunction

   task automatic fill(input int mode);
      for (int i = 0; i < PIX; i++)
         case (mode)
            0:       src[i] = 4'(i % 16);
            1:       src[i] = 4'd9;
            default: src[i] = 4'($urandom_range(0, 15));
         endcase
   endtask

   task automatic check_idle_outs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_rd_en"}, src_rd_en, 0);
      check({tag, "_rd_addr"}, src_rd_addr, 0);
      check({tag, "_frst"}, filt_rst, 0);
      check({tag, "_in_rdy"}, filt_in_ready, 0);
      check({tag, "_pix_in"}, filt_pixel_in, 0);
      check({tag, "_wr_en"}, dst_wr_en, 0);
      check({tag, "_wr_addr"}, dst_wr_addr, 0);
      check({tag, "_wr_data"}, dst_wr_data, 0);
   endtask

   task automatic run_frame(input bit extra);
      bit got;
      int n;
      clear_mon();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("busy_after_start", busy, 1);
      check("frst_after_start", filt_rst, 1);
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (extra && i == 10)
            start = 1'b1;
         else if (extra && i == 11)
            start = 1'b0;
         if (done) begin
            got = 1'b1;
            check("busy_at_done", busy, 0);
            if (extra)
               start = 1'b1;
         end
      end
      @(posedge clk); #1 start = 1'b0;
      check("done_seen", got, 1);
      repeat (8) @(negedge clk);
      check("idle_after", busy, 0);
      check("done_count", done_n, 1);
      check("frst_count", frst_n, 1);
      check("in_count", in_q.size(), PIX + CO + PAD);
      check("in_contig", in_last - in_first + 1, in_q.size());
      n = (in_q.size() < PIX + CO + PAD) ? in_q.size() : PIX + CO + PAD;
      for (int k = 0; k < n; k++)
         check($sformatf("in_pix[%0d]", k), in_q[k], s_at(k));
      check("wr_count", wa_q.size(), PIX);
      n = (wa_q.size() < PIX) ? wa_q.size() : PIX;
      for (int m = 0; m < n; m++) begin
         check($sformatf("wr_addr[%0d]", m), wa_q[m], m);
         check($sformatf("wr_data[%0d]", m), wd_q[m], exp_wr(m));
      end
   endtask

   initial begin
      bit seen;
      fill(0);
      #12;
      check_idle_outs("reset");
      @(negedge clk) rst = 1'b0;

      fill(0);
      run_frame(1'b0);
      fill(1);
      run_frame(1'b0);
      for (int t = 0; t < 3; t++) begin
         fill(2);
         run_frame(1'b0);
      end

      fill(2);
      run_frame(1'b1);

      // abort in the tenth FEED cycle
      fill(2);
      clear_mon();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = src_rd_en;
      end
      check("abort_feed_seen", seen, 1);
      repeat (9) @(negedge clk);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      check_idle_outs("abort");
      clear_mon();
      repeat (60) @(negedge clk);
      check("abort_no_wr", wa_q.size(), 0);
      check("abort_no_done", done_n, 0);
      check("abort_no_in", in_q.size(), 0);
      fill(2);
      run_frame(1'b0);

      // asynchronous reset in the middle of FLUSH
      fill(2);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = src_rd_en;
      end
      check("rst_feed_seen", seen, 1);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = !src_rd_en;
      end
      check("rst_flush_seen", seen, 1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check_idle_outs("rst_flush");
      @(negedge clk) rst = 1'b0;
      fill(0);
      run_frame(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/edge_frame_sequencer.md
Name: edge_frame_sequencer

Overview:
Frame-level controller for the 5x5 edge filter. On start it resets the filter and streams one IMG_W x IMG_H 4-bit frame from a source frame memory into the filter as a gap-free pixel stream. It then flushes the filter's line buffers and pipeline with zero pixels. Aligned filter outputs go to a destination frame memory, with a forced-zero 2-pixel border, giving exactly IMG_W*IMG_H writes per frame.

Parameters:
IMG_W, 638, frame width in pixels
IMG_H, 478, frame height in pixels
ADDR_W, 19, frame memory address width (must hold IMG_W*IMG_H-1)
CENTER_OFS, 2*IMG_W+2, number of leading filter output strobes discarded before the first valid window centre
FLUSH_PAD, 2, extra zero pixels fed beyond CENTER_OFS to push the last window through the filter pipeline

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to process a frame; ignored while busy
abort  in  1  synchronous abort; returns to IDLE next cycle, no done
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse after the last destination write
src_rd_en  out  1  source memory read strobe
src_rd_addr  out  ADDR_W  source read address (row-major)
src_rd_data  in  4  source pixel, valid exactly 1 cycle after src_rd_en
filt_rst  out  1  filter reset, one-cycle pulse
filt_pixel_in  out  4  pixel to filter
filt_in_ready  out  1  filter input strobe
filt_pixel_out  in  4  filter result
filt_out_ready  in  1  filter output strobe
dst_wr_en  out  1  destination write strobe
dst_wr_addr  out  ADDR_W  destination address (row-major)
dst_wr_data  out  4  destination pixel

Behaviour:
- Reset (async) and abort: state IDLE. busy, done, src_rd_en, filt_in_ready, dst_wr_en and filt_rst are 0. All addresses, counters and filt_pixel_in are 0.
- States: IDLE -> CLEAR -> FEED -> FLUSH -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 -> CLEAR.
- CLEAR, 1 cycle: filt_rst=1 (clears filter line buffers and column pointer); busy=1.
- FEED: src_rd_en=1 every cycle, src_rd_addr 0..IMG_W*IMG_H-1 incrementing by 1. Leave after the last address is issued.
- Source path, registered: filt_in_ready = src_rd_en delayed 1 cycle; filt_pixel_in = src_rd_data.
- FLUSH: filt_in_ready=1 and filt_pixel_in=0 for CENTER_OFS+FLUSH_PAD cycles. The first flush strobe immediately follows the last real pixel strobe. filt_in_ready must have no gaps from the first real pixel to the last flush pixel, because the filter's multiply stage is gated by in_ready.
- Output side, independent of state while busy:
  - k counts filt_out_ready pulses from 0.
  - For k < CENTER_OFS: no write.
  - Otherwise m = k - CENTER_OFS, with r = m / IMG_W and c = m mod IMG_W tracked as counters, not dividers.
  - dst_wr_en=1, dst_wr_addr=m.
  - dst_wr_data = filt_pixel_out if 2<=r<=IMG_H-3 and 2<=c<=IMG_W-3, else 0.
  - Write outputs are registered: 1 cycle after filt_out_ready.
- DRAIN: wait until the write for m = IMG_W*IMG_H-1 has been issued; pulses beyond that produce no write.
- DONE: 1 cycle, done=1, busy=0 -> IDLE. A start in the DONE cycle is ignored.
- start while busy: ignored, no effect on counters.
- abort in any state: writes stop immediately (dst_wr_en=0 next cycle). The filter state is discarded by the next CLEAR.
- Widths: m, r and c counters sized from IMG_W and IMG_H. CENTER_OFS+FLUSH_PAD counter is ADDR_W bits. No arithmetic overflow is permitted for the default parameters.

Decomposition:
- Package edge_pkg holds:
  - the state enum seq_state_t (IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE);
  - localparams FRAME_PIX = IMG_W*IMG_H and BORDER = 2;
  - the frame-dimension defaults shared with the filter.
- One sub-module, edge_wr_mapper, owns the output side: the k/m/r/c counters, border test, discard logic and write registers. It exposes a last_write flag to the main FSM.

Test Plan:
- 8x6 frame (IMG_W=8, IMG_H=6, CENTER_OFS=18), source ramp pix=i mod 16, start pulse -> filt_rst pulse for 1 cycle, then 48 contiguous filt_in_ready with values 0,1,..,15,0,..; then 20 zero strobes; exactly 48 writes to addresses 0..47 in order; done pulses once.
- Same frame, checking the border -> addresses with r in {0,1,4,5} or c in {0,1,6,7} are written 0; interior addresses (r 2..3, c 2..5) match the golden 5x5 filter model.
- Uniform frame (all pixels 9) -> every interior write is 0 and every border write is 0.
- start asserted during FEED and again in the DONE cycle -> no restart, addresses unaffected, single done.
- abort at cycle 10 of FEED -> busy=0 and src_rd_en=0 next cycle, no further writes, no done. A following start runs a clean full frame matching the golden output.
- rst asserted mid-FLUSH -> all outputs 0 immediately, state IDLE. The next start produces a correct 48-write frame.
